lsu_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one data-memory port between `CORES` load/store units in a multi-core build. Each load/store unit presents a single-word read or write request and holds it until it sees its hit pulse. The arbiter grants one requester at a time and forwards its request to the memory port. It then returns the memory response only to that requester. It sits between the per-core load/store units and the shared data cache / memory controller.

---
 rtl/lsu_mem_arbiter_if.sv | 34 +++
 rtl/lsu_mem_arbiter.sv | 110 +++++++++++
 tb/tb_lsu_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_arbiter_if.sv
// Request/response bundle shared by the load/store units, the arbiter and the data-memory port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface lsu_mem_arbiter_if #(
   parameter int unsigned CORES = 2
);
   localparam int unsigned IDW = $clog2(CORES);

   logic [CORES-1:0]       reqREN;
   logic [CORES-1:0]       reqWEN;
   logic [CORES-1:0][31:0] reqaddr;
   logic [CORES-1:0][31:0] reqstore;
   logic [CORES-1:0]       reqHit;
   logic [31:0]            reqload;

   logic                   memREN;
   logic                   memWEN;
   logic [31:0]            memaddr;
   logic [31:0]            memstore;
   logic [31:0]            memload;
   logic                   memReady;

   logic                   grantValid;
   logic [IDW-1:0]         grantId;

   modport slave (
      input  reqREN, reqWEN, reqaddr, reqstore, memload, memReady,
      output reqHit, reqload, memREN, memWEN, memaddr, memstore, grantValid, grantId
   );

   modport master (
      output reqREN, reqWEN, reqaddr, reqstore, memload, memReady,
      input  reqHit, reqload, memREN, memWEN, memaddr, memstore, grantValid, grantId
   );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between CORES load/store units.
// One grant at a time; the memory response is returned only to the granted requester.
module lsu_mem_arbiter #(
   parameter int unsigned CORES = 2
) (
   input logic              CLK,
   input logic              nRST,
   lsu_mem_arbiter_if.slave bus
);
   localparam int unsigned IDW = $clog2(CORES);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   logic [CORES-1:0] act;
   logic [IDW-1:0]   pick;
   logic             pick_vld;
   logic             gnt_act;

   logic             mem_ren, mem_wen;
   logic [31:0]      mem_addr, mem_store;
   logic [CORES-1:0] req_hit;
   logic [31:0]      req_load;

   assign act = bus.reqREN | bus.reqWEN;

   // Cyclic search starting at ptr_q; the first active requester found wins.
   always_comb begin
      logic [IDW-1:0] cand;
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int unsigned k = 0; k < CORES; k++) begin
         cand = IDW'((32'(ptr_q) + k) % CORES);
         if (!pick_vld && act[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_store = '0;
      req_hit   = '0;
      req_load  = '0;
      gnt_act   = act[grant_q];

      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = StBusy;
            end
         end
         StBusy: begin
            mem_addr  = bus.reqaddr[grant_q];
            mem_store = bus.reqstore[grant_q];
            if (!gnt_act) begin
               // Requester withdrew: abandon the grant, keep the pointer where it was.
               state_d = StIdle;
               grant_d = '0;
            end else begin
               mem_wen = bus.reqWEN[grant_q];
               mem_ren = bus.reqREN[grant_q] & ~bus.reqWEN[grant_q];
               if (bus.memReady) begin
                  req_hit[grant_q] = 1'b1;
                  req_load         = bus.memload;
                  ptr_d            = (grant_q == IDW'(CORES - 1)) ? '0 : grant_q + 1'b1;
                  state_d          = StIdle;
                  grant_d          = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.memREN     = mem_ren;
   assign bus.memWEN     = mem_wen;
   assign bus.memaddr    = mem_addr;
   assign bus.memstore   = mem_store;
   assign bus.reqHit     = req_hit;
   assign bus.reqload    = req_load;
   assign bus.grantValid = (state_q == StBusy);
   assign bus.grantId    = grant_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed scenarios then randomized traffic, every cycle checked against a behavioural model.
module tb_lsu_mem_arbiter;
   localparam int unsigned CORES = 4;
   localparam int unsigned IDW   = $clog2(CORES);

   logic CLK = 1'b0;
   logic nRST;
   int   tests = 0;
   int   fails = 0;

   lsu_mem_arbiter_if #(.CORES(CORES)) bus ();
   lsu_mem_arbiter #(.CORES(CORES)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   always #5 CLK = ~CLK;

   // Model: current owner (-1 when none) and the requester most recently completed.
   int               m_owner;
   int               m_last;
   int               waiting [CORES];

   logic [CORES-1:0] obs_hit;
   logic             obs_gv, obs_ren, obs_wen;
   logic [31:0]      obs_addr, obs_store, obs_load;
   logic [IDW-1:0]   obs_gid;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = CORES - 1;
      for (int i = 0; i < CORES; i++) waiting[i] = 0;
   endtask

   task automatic set_req(input int i, input logic ren, input logic wen,
                          input logic [31:0] a, input logic [31:0] d);
      bus.reqREN[i]   = ren;
      bus.reqWEN[i]   = wen;
      bus.reqaddr[i]  = a;
      bus.reqstore[i] = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < CORES; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
   task automatic step();
      logic [CORES-1:0] act, e_hit;
      logic             e_ren, e_wen, e_gv;
      logic [31:0]      e_addr, e_store, e_load;
      int               e_gid, g;
      @(negedge CLK);
      act     = bus.reqREN | bus.reqWEN;
      e_hit   = '0;
      e_ren   = 1'b0;
      e_wen   = 1'b0;
      e_gv    = 1'b0;
      e_addr  = '0;
      e_store = '0;
      e_load  = '0;
      e_gid   = 0;
      g       = m_owner;
      if (nRST && g >= 0) begin
         e_gv    = 1'b1;
         e_gid   = g;
         e_addr  = bus.reqaddr[g];
         e_store = bus.reqstore[g];
         if (act[g]) begin
            e_wen = bus.reqWEN[g];
            e_ren = bus.reqREN[g] && !bus.reqWEN[g];
            if (bus.memReady) begin
               e_hit[g] = 1'b1;
               e_load   = bus.memload;
            end
         end
      end
      obs_hit   = bus.reqHit;
      obs_gv    = bus.grantValid;
      obs_gid   = bus.grantId;
      obs_ren   = bus.memREN;
      obs_wen   = bus.memWEN;
      obs_addr  = bus.memaddr;
      obs_store = bus.memstore;
      obs_load  = bus.reqload;
      chk("reqHit", obs_hit, e_hit);
      chk("grantValid", obs_gv, e_gv);
      chk("grantId", obs_gid, e_gid);
      chk("memREN", obs_ren, e_ren);
      chk("memWEN", obs_wen, e_wen);
      chk("memaddr", obs_addr, e_addr);
      chk("memstore", obs_store, e_store);
      chk("reqload", obs_load, e_load);

      for (int i = 0; i < CORES; i++) if (!act[i]) waiting[i] = 0;
      if (e_hit != '0) begin
         for (int i = 0; i < CORES; i++) if (i != g && act[i]) waiting[i]++;
         chk("fairness", waiting[g] <= CORES - 1, 1);
         waiting[g] = 0;
      end

      if (!nRST) begin
         model_reset();
      end else if (m_owner >= 0) begin
         if (!act[m_owner]) m_owner = -1;
         else if (bus.memReady) begin
            m_last  = m_owner;
            m_owner = -1;
         end
      end else begin
         for (int k = 1; k <= CORES; k++) begin
            int w;
            w = (m_last + k) % CORES;
            if (act[w]) begin
               m_owner = w;
               break;
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      step();
      nRST = 1'b1;
   endtask

   int order[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};
   int last_hit;
   int h;

   initial begin
      nRST         = 1'b0;
      bus.memReady = 1'b0;
      bus.memload  = '0;
      clear_all();
      model_reset();
      step();
      chk("reset_gv", obs_gv, 0);
      chk("reset_hit", obs_hit, 0);
      nRST = 1'b1;

      // Single requester read
      set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
      step();
      chk("single_idle_gv", obs_gv, 0);
      step();
      chk("single_ren", obs_ren, 1);
      chk("single_addr", obs_addr, 32'h100);
      bus.memReady = 1'b1;
      bus.memload  = 32'hDEADBEEF;
      step();
      chk("single_hit", obs_hit, 4'b0001);
      chk("single_load", obs_load, 32'hDEADBEEF);
      clear_all();
      bus.memReady = 1'b0;
      step();
      chk("single_back_idle", obs_gv, 0);

      // Contention from reset, memory always ready
      do_reset();
      for (int i = 0; i < CORES; i++) set_req(i, 1'b1, 1'b0, 32'h10 * i, 32'h0);
      bus.memReady = 1'b1;
      last_hit     = -100;
      for (int c = 0; c < 16 && order.size() < 5; c++) begin
         step();
         if (obs_hit != '0) begin
            h = 0;
            for (int i = 0; i < CORES; i++) if (obs_hit[i]) h = i;
            if (order.size() > 0) chk("rr_spacing", c - last_hit, 2);
            last_hit = c;
            order.push_back(h);
         end
         for (int i = 0; i < CORES; i++) begin
            if (obs_hit[i]) bus.reqREN[i] = 1'b0;
            else if (!bus.reqREN[i]) bus.reqREN[i] = 1'b1;
         end
      end
      chk("rr_count", order.size(), 5);
      for (int n = 0; n < order.size() && n < 5; n++) chk("rr_order", order[n], exp_order[n]);
      clear_all();
      bus.memReady = 1'b0;
      step();
      step();

      // Write wins over read
      set_req(1, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A);
      step();
      step();
      chk("wr_wen", obs_wen, 1);
      chk("wr_ren", obs_ren, 0);
      chk("wr_store", obs_store, 32'h5A5A5A5A);
      bus.memReady = 1'b1;
      step();
      chk("wr_hit", obs_hit, 4'b0010);
      clear_all();
      bus.memReady = 1'b0;
      step();

      // Memory stall with a competing requester waiting
      set_req(2, 1'b1, 1'b0, 32'h2200, 32'h0);
      step();
      set_req(0, 1'b1, 1'b0, 32'h0A00, 32'h0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_addr", obs_addr, 32'h2200);
         chk("stall_nohit", obs_hit, 0);
      end
      bus.memReady = 1'b1;
      step();
      chk("stall_hit2", obs_hit, 4'b0100);
      set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
      bus.memReady = 1'b0;
      step();
      step();
      chk("stall_then_gid0", obs_gid, 0);
      chk("stall_then_gv", obs_gv, 1);
      bus.memReady = 1'b1;
      step();
      chk("stall_hit0", obs_hit, 4'b0001);
      clear_all();
      bus.memReady = 1'b0;
      step();

      // Withdraw in the second busy cycle; pointer must stay on requester 1
      set_req(1, 1'b1, 1'b0, 32'h1100, 32'h0);
      step();
      step();
      chk("wd_ren_busy1", obs_ren, 1);
      bus.reqREN[1] = 1'b0;
      step();
      chk("wd_ren_dropped", obs_ren, 0);
      chk("wd_nohit", obs_hit, 0);
      set_req(0, 1'b1, 1'b0, 32'h0A00, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h1100, 32'h0);
      step();
      chk("wd_idle", obs_gv, 0);
      step();
      chk("wd_ptr_kept", obs_gid, 1);
      bus.memReady = 1'b1;
      step();
      bus.reqREN[1] = 1'b0;
      step();
      step();
      chk("wd_then_hit0", obs_hit, 4'b0001);
      clear_all();
      bus.memReady = 1'b0;
      step();

      // Asynchronous reset while busy
      set_req(2, 1'b1, 1'b0, 32'h2200, 32'h0);
      step();
      step();
      #2;
      nRST = 1'b0;
      #1;
      chk("arst_gv", bus.grantValid, 0);
      chk("arst_ren", bus.memREN, 0);
      chk("arst_addr", bus.memaddr, 0);
      chk("arst_gid", bus.grantId, 0);
      model_reset();
      step();
      nRST = 1'b1;
      set_req(0, 1'b1, 1'b0, 32'h0A00, 32'h0);
      step();
      step();
      chk("arst_first_gid", obs_gid, 0);
      clear_all();
      step();
      step();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         bus.memReady = ($urandom_range(0, 2) != 0);
         bus.memload  = $urandom();
         for (int i = 0; i < CORES; i++) begin
            if (obs_hit[i]) begin
               set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (bus.reqREN[i] || bus.reqWEN[i]) begin
               if ($urandom_range(0, 39) == 0) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if ($urandom_range(0, 2) == 0) begin
               logic r;
               r = 1'($urandom_range(0, 1));
               set_req(i, r, r ? 1'($urandom_range(0, 1)) : 1'b1, $urandom(), $urandom());
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
